// File: rtl/cnn_mac_controller_if.sv
// Bus bundle between the CNN MAC sequencer, its pixel/weight front end and the shared ALU.
// The master modport is the sequencer side; the slave modport is the environment side.
interface cnn_mac_controller_if;
    logic        start;
    logic        shr_en;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic [15:0] w_data;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        busy;
    logic        done;
    logic [15:0] acc_out;
    logic        ovf;

    modport master (
        input  start, shr_en, pix_valid, pix_data, w_data, alu_result, alu_carry,
        output pix_ready, alu_op, alu_a, alu_b, busy, done, acc_out, ovf
    );

    modport slave (
        output start, shr_en, pix_valid, pix_data, w_data, alu_result, alu_carry,
        input  pix_ready, alu_op, alu_a, alu_b, busy, done, acc_out, ovf
    );
endinterface

// File: rtl/cnn_mac_controller.sv
// Dot-product sequencer driving a shared combinational ALU: MUL then ADD per pair, optional SHR4.
// Optional feature macro: MAC_RELU_EN clamps a negative result to zero on entry to DONE.
module cnn_mac_controller #(
    parameter int LEN   = 9,
    parameter int CNT_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    cnn_mac_controller_if.master bus
);

    typedef enum logic [2:0] {IDLE, FETCH, MUL, ADD, SCALE, DONE} state_t;

    localparam logic [3:0]       OP_ADD  = 4'h0;
    localparam logic [3:0]       OP_MUL  = 4'h2;
    localparam logic [3:0]       OP_SHR4 = 4'h4;
    localparam logic [3:0]       OP_IDLE = 4'hF;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(LEN - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [15:0]      acc, acc_next, prod, prod_next;
    logic [15:0]      pix_q, pix_q_next, w_q, w_q_next;
    logic             ovf, ovf_next, shr_q, shr_q_next;
    logic [3:0]       op_q, op_next;
    logic [15:0]      a_q, a_next, b_q, b_next;
    logic             busy_q, busy_next, done_q, done_next, ready_q, ready_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            prod    <= '0;
            pix_q   <= '0;
            w_q     <= '0;
            ovf     <= 1'b0;
            shr_q   <= 1'b0;
            op_q    <= OP_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            acc     <= acc_next;
            prod    <= prod_next;
            pix_q   <= pix_q_next;
            w_q     <= w_q_next;
            ovf     <= ovf_next;
            shr_q   <= shr_q_next;
            op_q    <= op_next;
            a_q     <= a_next;
            b_q     <= b_next;
            busy_q  <= busy_next;
            done_q  <= done_next;
            ready_q <= ready_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = FETCH;
            FETCH:   if (bus.pix_valid) state_next = MUL;
            MUL:     state_next = ADD;
            ADD:     if (cnt == LAST) state_next = shr_q ? SCALE : DONE;
                     else state_next = FETCH;
            SCALE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath updates follow the current state; the ALU drive is decoded from the
    // next state and registered so it lines up with the cycle that consumes it.
    always_comb begin
        cnt_next   = cnt;
        acc_next   = acc;
        prod_next  = prod;
        pix_q_next = pix_q;
        w_q_next   = w_q;
        ovf_next   = ovf;
        shr_q_next = shr_q;
        op_next    = OP_IDLE;
        a_next     = '0;
        b_next     = '0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        ready_next = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    shr_q_next = bus.shr_en;
                end
            end
            FETCH: begin
                if (bus.pix_valid) begin
                    pix_q_next = bus.pix_data;
                    w_q_next   = bus.w_data;
                end
            end
            MUL: begin
                prod_next = bus.alu_result;
                ovf_next  = ovf | bus.alu_carry;
            end
            ADD: begin
                acc_next = bus.alu_result;
                ovf_next = ovf | bus.alu_carry;
                if (cnt != LAST) cnt_next = cnt + CNT_W'(1);
            end
            SCALE:   acc_next = bus.alu_result;
            default: ;
        endcase

`ifdef MAC_RELU_EN
        if (state_next == DONE && state != DONE && acc_next[15]) acc_next = '0;
`endif

        case (state_next)
            FETCH: begin
                ready_next = 1'b1;
                busy_next  = 1'b1;
            end
            MUL: begin
                op_next   = OP_MUL;
                a_next    = pix_q_next;
                b_next    = w_q_next;
                busy_next = 1'b1;
            end
            ADD: begin
                op_next   = OP_ADD;
                a_next    = acc_next;
                b_next    = prod_next;
                busy_next = 1'b1;
            end
            SCALE: begin
                op_next   = OP_SHR4;
                a_next    = acc_next;
                busy_next = 1'b1;
            end
            DONE:    done_next = 1'b1;
            default: ;
        endcase
    end

    assign bus.pix_ready = ready_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.acc_out   = acc;
    assign bus.ovf       = ovf;

endmodule

// File: tb/tb_cnn_mac_controller.sv
// Bench for cnn_mac_controller: a LEN=3 and a LEN=1 instance, behavioural ALU and dot-product model.
module tb_cnn_mac_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_mac_controller_if bus3 ();
    cnn_mac_controller_if bus1 ();

    cnn_mac_controller #(.LEN(3), .CNT_W(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    cnn_mac_controller #(.LEN(1), .CNT_W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Index 0 drives the LEN=3 instance, index 1 the LEN=1 instance.
    logic [1:0]  start_d, shr_d, valid_d;
    logic [15:0] pix_d [2];
    logic [15:0] w_d   [2];
    logic [1:0]  ready_o, busy_o, done_o, ovf_o;
    logic [15:0] acc_o [2];
    logic [15:0] a_o   [2];
    logic [15:0] b_o   [2];
    logic [3:0]  op_o  [2];

    function automatic logic [16:0] alu_eval(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            4'h2:    return {|p[31:16], p[15:0]};
            4'h0:    return {1'b0, a} + {1'b0, b};
            4'h4:    return {1'b0, a >> 4};
            default: return 17'h0;
        endcase
    endfunction

    assign {bus3.alu_carry, bus3.alu_result} = alu_eval(bus3.alu_op, bus3.alu_a, bus3.alu_b);
    assign {bus1.alu_carry, bus1.alu_result} = alu_eval(bus1.alu_op, bus1.alu_a, bus1.alu_b);

    assign bus3.start     = start_d[0];
    assign bus3.shr_en    = shr_d[0];
    assign bus3.pix_valid = valid_d[0];
    assign bus3.pix_data  = pix_d[0];
    assign bus3.w_data    = w_d[0];
    assign bus1.start     = start_d[1];
    assign bus1.shr_en    = shr_d[1];
    assign bus1.pix_valid = valid_d[1];
    assign bus1.pix_data  = pix_d[1];
    assign bus1.w_data    = w_d[1];

    assign ready_o = {bus1.pix_ready, bus3.pix_ready};
    assign busy_o  = {bus1.busy, bus3.busy};
    assign done_o  = {bus1.done, bus3.done};
    assign ovf_o   = {bus1.ovf, bus3.ovf};
    assign acc_o[0] = bus3.acc_out;
    assign acc_o[1] = bus1.acc_out;
    assign a_o[0]   = bus3.alu_a;
    assign a_o[1]   = bus1.alu_a;
    assign b_o[0]   = bus3.alu_b;
    assign b_o[1]   = bus1.alu_b;
    assign op_o[0]  = bus3.alu_op;
    assign op_o[1]  = bus1.alu_op;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] pix_vec [8];
    logic [15:0] w_vec   [8];
    int          stall_vec [8];

    int          obs_done_cycle, obs_ready_cycles, obs_busy_cycles, obs_ready_bad;
    logic [15:0] obs_acc, obs_acc_after;
    logic        obs_ovf, obs_done_after, obs_busy_after;
    logic [15:0] exp_acc;
    logic        exp_ovf;
    int          exp_done, exp_stalls;

    // Dot product from first principles: wide products and sums, then modular reduction.
    task automatic model_expect(input int len, input bit shr);
        longint unsigned acc, p;
        acc = 0;
        exp_ovf = 1'b0;
        exp_stalls = 0;
        for (int k = 0; k < len; k++) begin
            p = pix_vec[k];
            p = p * w_vec[k];
            if (p >= 65536) exp_ovf = 1'b1;
            acc = acc + (p % 65536);
            if (acc >= 65536) begin
                exp_ovf = 1'b1;
                acc = acc - 65536;
            end
            exp_stalls += stall_vec[k];
        end
        if (shr) acc = acc / 16;
`ifdef MAC_RELU_EN
        if (!shr && acc >= 32768) acc = 0;
`endif
        exp_acc  = 16'(acc);
        exp_done = 3 * len + 1 + (shr ? 1 : 0) + exp_stalls;
    endtask

    // Called at a negedge in an IDLE cycle; that cycle is cycle 0 (start sampled).
    task automatic applyStimulus(input int sel, input int len, input bit shr, input int inject_start);
        int  k, stall_left;
        bit  pend;
        obs_done_cycle   = -1;
        obs_ready_cycles = 0;
        obs_busy_cycles  = 0;
        obs_ready_bad    = 0;
        obs_acc          = 16'hxxxx;
        obs_ovf          = 1'bx;
        k = 0;
        stall_left = stall_vec[0];
        pend = 1'b0;
        start_d[sel] = 1'b1;
        shr_d[sel]   = shr;
        valid_d[sel] = 1'b0;
        for (int cycle = 1; cycle <= 300; cycle++) begin
            @(negedge clk);
            start_d[sel] = (cycle == inject_start);
            if (pend) begin
                k++;
                stall_left = (k < len) ? stall_vec[k] : 0;
            end
            if (busy_o[sel]) obs_busy_cycles++;
            if (ready_o[sel]) begin
                obs_ready_cycles++;
                if (!busy_o[sel] || op_o[sel] != 4'hF) obs_ready_bad++;
            end
            if (done_o[sel]) begin
                obs_done_cycle = cycle;
                obs_acc = acc_o[sel];
                obs_ovf = ovf_o[sel];
                break;
            end
            if (k < len && stall_left == 0) begin
                valid_d[sel] = 1'b1;
                pix_d[sel]   = pix_vec[k];
                w_d[sel]     = w_vec[k];
            end else begin
                valid_d[sel] = 1'b0;
                pix_d[sel]   = 16'($urandom);
                w_d[sel]     = 16'($urandom);
                if (ready_o[sel] && stall_left > 0) stall_left--;
            end
            pend = valid_d[sel] && ready_o[sel];
        end
        start_d[sel] = 1'b0;
        valid_d[sel] = 1'b0;
        @(negedge clk);
        obs_done_after = done_o[sel];
        obs_busy_after = busy_o[sel];
        obs_acc_after  = acc_o[sel];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_d = 2'b11;
        shr_d   = 2'b11;
        valid_d = 2'b11;
        for (int s = 0; s < 2; s++) begin
            pix_d[s] = 16'($urandom);
            w_d[s]   = 16'($urandom);
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            tests_run++;
            if ({ready_o[s], busy_o[s], done_o[s], ovf_o[s], op_o[s], acc_o[s], a_o[s], b_o[s]}
                !== {4'b0000, 4'hF, 48'h0}) begin
                tests_failed++;
                $display("[TB] FAIL reset_outputs[%0d]: got rdy=%b busy=%b done=%b ovf=%b op=%h acc=%h a=%h b=%h, expected 0,0,0,0,F,0,0,0",
                         s, ready_o[s], busy_o[s], done_o[s], ovf_o[s], op_o[s], acc_o[s], a_o[s], b_o[s]);
            end
        end
        start_d = 2'b00;
        shr_d   = 2'b00;
        valid_d = 2'b00;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pix_vec[0] = 16'd1; w_vec[0] = 16'd4; stall_vec[0] = 0;
        pix_vec[1] = 16'd2; w_vec[1] = 16'd5; stall_vec[1] = 0;
        pix_vec[2] = 16'd3; w_vec[2] = 16'd6; stall_vec[2] = 0;
        model_expect(3, 1'b0);
        applyStimulus(0, 3, 1'b0, -1);
        tests_run++;
        if (obs_done_cycle !== 10) begin
            tests_failed++;
            $display("[TB] FAIL basic_done_cycle: got %0d expected 10", obs_done_cycle);
        end
        tests_run++;
        if (obs_acc !== exp_acc || obs_ovf !== exp_ovf) begin
            tests_failed++;
            $display("[TB] FAIL basic_result: got acc=%h ovf=%b expected acc=%h ovf=%b", obs_acc, obs_ovf, exp_acc, exp_ovf);
        end
        tests_run++;
        if (obs_busy_cycles !== 9 || obs_ready_cycles !== 3 || obs_ready_bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL basic_busy_ready: got busy=%0d ready=%0d bad=%0d expected 9 3 0",
                     obs_busy_cycles, obs_ready_cycles, obs_ready_bad);
        end
        tests_run++;
        if (obs_done_after !== 1'b0 || obs_busy_after !== 1'b0 || obs_acc_after !== exp_acc) begin
            tests_failed++;
            $display("[TB] FAIL basic_after_done: got done=%b busy=%b acc=%h expected 0 0 %h",
                     obs_done_after, obs_busy_after, obs_acc_after, exp_acc);
        end
    endtask

    task automatic test_scale();
        pix_vec[0] = 16'd16; w_vec[0] = 16'd1; stall_vec[0] = 0;
        pix_vec[1] = 16'd32; w_vec[1] = 16'd1; stall_vec[1] = 0;
        pix_vec[2] = 16'd48; w_vec[2] = 16'd1; stall_vec[2] = 0;
        model_expect(3, 1'b1);
        applyStimulus(0, 3, 1'b1, -1);
        tests_run++;
        if (obs_done_cycle !== 11 || obs_busy_cycles !== 10) begin
            tests_failed++;
            $display("[TB] FAIL scale_timing: got done=%0d busy=%0d expected 11 10", obs_done_cycle, obs_busy_cycles);
        end
        tests_run++;
        if (obs_acc !== exp_acc || obs_ovf !== exp_ovf) begin
            tests_failed++;
            $display("[TB] FAIL scale_result: got acc=%h ovf=%b expected acc=%h ovf=%b", obs_acc, obs_ovf, exp_acc, exp_ovf);
        end
    endtask

    task automatic test_len1_ovf();
        pix_vec[0] = 16'h0100; w_vec[0] = 16'h0100; stall_vec[0] = 0;
        model_expect(1, 1'b0);
        applyStimulus(1, 1, 1'b0, -1);
        tests_run++;
        if (obs_acc !== exp_acc || obs_ovf !== exp_ovf || obs_done_cycle !== 4) begin
            tests_failed++;
            $display("[TB] FAIL len1_ovf: got acc=%h ovf=%b done=%0d expected acc=%h ovf=%b done=4",
                     obs_acc, obs_ovf, obs_done_cycle, exp_acc, exp_ovf);
        end
        pix_vec[0] = 16'd2; w_vec[0] = 16'd3;
        model_expect(1, 1'b0);
        applyStimulus(1, 1, 1'b0, -1);
        tests_run++;
        if (obs_acc !== exp_acc || obs_ovf !== exp_ovf || obs_done_cycle !== 4) begin
            tests_failed++;
            $display("[TB] FAIL len1_ovf_clear: got acc=%h ovf=%b done=%0d expected acc=%h ovf=%b done=4",
                     obs_acc, obs_ovf, obs_done_cycle, exp_acc, exp_ovf);
        end
    endtask

    task automatic test_stall_and_start();
        for (int k = 0; k < 3; k++) begin
            pix_vec[k] = 16'($urandom_range(0, 300));
            w_vec[k]   = 16'($urandom_range(0, 300));
            stall_vec[k] = 0;
        end
        stall_vec[1] = 4;
        model_expect(3, 1'b0);
        applyStimulus(0, 3, 1'b0, 5);
        tests_run++;
        if (obs_done_cycle !== 14) begin
            tests_failed++;
            $display("[TB] FAIL stall_done_cycle: got %0d expected 14", obs_done_cycle);
        end
        tests_run++;
        if (obs_ready_cycles !== 7 || obs_ready_bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL stall_ready: got ready=%0d bad=%0d expected 7 0", obs_ready_cycles, obs_ready_bad);
        end
        tests_run++;
        if (obs_acc !== exp_acc || obs_ovf !== exp_ovf) begin
            tests_failed++;
            $display("[TB] FAIL stall_result: got acc=%h ovf=%b expected acc=%h ovf=%b", obs_acc, obs_ovf, exp_acc, exp_ovf);
        end
    endtask

    task automatic test_relu();
        pix_vec[0] = 16'hFFFF; w_vec[0] = 16'd1; stall_vec[0] = 0;
        model_expect(1, 1'b0);
        applyStimulus(1, 1, 1'b0, -1);
        tests_run++;
        if (obs_acc !== exp_acc || obs_ovf !== exp_ovf) begin
            tests_failed++;
            $display("[TB] FAIL relu_noshr: got acc=%h ovf=%b expected acc=%h ovf=%b", obs_acc, obs_ovf, exp_acc, exp_ovf);
        end
        model_expect(1, 1'b1);
        applyStimulus(1, 1, 1'b1, -1);
        tests_run++;
        if (obs_acc !== exp_acc || obs_done_cycle !== exp_done) begin
            tests_failed++;
            $display("[TB] FAIL relu_shr: got acc=%h done=%0d expected acc=%h done=%0d", obs_acc, obs_done_cycle, exp_acc, exp_done);
        end
    endtask

    task automatic test_reset_mid_run();
        int  muls;
        bit  hit, spurious;
        muls = 0;
        hit = 1'b0;
        spurious = 1'b0;
        start_d[0] = 1'b1;
        shr_d[0]   = 1'b0;
        valid_d[0] = 1'b1;
        pix_d[0]   = 16'd5;
        w_d[0]     = 16'd7;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            start_d[0] = 1'b0;
            if (op_o[0] == 4'h2) begin
                muls++;
                if (muls == 2) hit = 1'b1;
            end
        end
        tests_run++;
        if (hit !== 1'b1 || acc_o[0] !== 16'd35) begin
            tests_failed++;
            $display("[TB] FAIL midrst_reach_mul: got hit=%b acc=%h expected 1 0023", hit, acc_o[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        valid_d[0] = 1'b0;
        tests_run++;
        if ({ready_o[0], busy_o[0], done_o[0], ovf_o[0], op_o[0], acc_o[0], a_o[0], b_o[0]}
            !== {4'b0000, 4'hF, 48'h0}) begin
            tests_failed++;
            $display("[TB] FAIL midrst_outputs: got rdy=%b busy=%b done=%b ovf=%b op=%h acc=%h a=%h b=%h",
                     ready_o[0], busy_o[0], done_o[0], ovf_o[0], op_o[0], acc_o[0], a_o[0], b_o[0]);
        end
        repeat (8) begin
            @(negedge clk);
            if (done_o[0] || busy_o[0]) spurious = 1'b1;
        end
        tests_run++;
        if (spurious !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_no_done: got activity=%b expected 0", spurious);
        end
        for (int k = 0; k < 3; k++) begin
            pix_vec[k] = 16'(k + 2); w_vec[k] = 16'(k + 9); stall_vec[k] = 0;
        end
        model_expect(3, 1'b0);
        applyStimulus(0, 3, 1'b0, -1);
        tests_run++;
        if (obs_acc !== exp_acc || obs_done_cycle !== exp_done) begin
            tests_failed++;
            $display("[TB] FAIL midrst_fresh_run: got acc=%h done=%0d expected acc=%h done=%0d",
                     obs_acc, obs_done_cycle, exp_acc, exp_done);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                pix_vec[k] = 16'($urandom);
                w_vec[k]   = 16'($urandom_range(0, 15));
                stall_vec[k] = 0;
            end
            model_expect(3, r[0]);
            applyStimulus(0, 3, r[0], -1);
            tests_run++;
            if (obs_acc !== exp_acc || obs_ovf !== exp_ovf || obs_done_cycle !== exp_done) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back[%0d]: got acc=%h ovf=%b done=%0d expected acc=%h ovf=%b done=%0d",
                         r, obs_acc, obs_ovf, obs_done_cycle, exp_acc, exp_ovf, exp_done);
            end
        end
    endtask

    task automatic test_random();
        int  sel, len;
        bit  shr;
        for (int it = 0; it < 12; it++) begin
            sel = it % 2;
            len = (sel == 0) ? 3 : 1;
            shr = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    pix_vec[k] = 16'($urandom_range(0, 255));
                    w_vec[k]   = 16'($urandom_range(0, 255));
                end else begin
                    pix_vec[k] = 16'($urandom);
                    w_vec[k]   = 16'($urandom);
                end
                stall_vec[k] = $urandom_range(0, 2);
            end
            model_expect(len, shr);
            applyStimulus(sel, len, shr, -1);
            tests_run++;
            if (obs_acc !== exp_acc || obs_ovf !== exp_ovf || obs_done_cycle !== exp_done) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d]: got acc=%h ovf=%b done=%0d expected acc=%h ovf=%b done=%0d",
                         it, obs_acc, obs_ovf, obs_done_cycle, exp_acc, exp_ovf, exp_done);
            end
            tests_run++;
            if (obs_ready_cycles !== len + exp_stalls || obs_ready_bad !== 0 || obs_busy_cycles !== exp_done - 1) begin
                tests_failed++;
                $display("[TB] FAIL random_handshake[%0d]: got ready=%0d bad=%0d busy=%0d expected %0d 0 %0d",
                         it, obs_ready_cycles, obs_ready_bad, obs_busy_cycles, len + exp_stalls, exp_done - 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start_d = 2'b00;
        shr_d   = 2'b00;
        valid_d = 2'b00;
        pix_d[0] = 16'h0; pix_d[1] = 16'h0;
        w_d[0]   = 16'h0; w_d[1]   = 16'h0;
        test_reset();
        test_basic();
        test_scale();
        test_len1_ovf();
        test_stall_and_start();
        test_relu();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
